// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and defaults for the inst/data SRAM-like request arbiter.
// Source tags identify which requester issued each outstanding transaction.
package sram_req_arbiter_pkg;

    typedef enum logic {
        ARB_SRC_INST = 1'b0,
        ARB_SRC_DATA = 1'b1
    } arb_src_e;

    localparam int ARB_OUTSTANDING_DEF = 2;

endpackage

// File: rtl/arb_src_fifo.sv
// In-order FIFO of 1-bit source tags, one entry per accepted-but-unanswered
// transaction; the head names the requester owed the next response.
module arb_src_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = ARB_OUTSTANDING_DEF,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  arb_src_e push_src,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output arb_src_e head
);

    arb_src_e         slots_q [DEPTH];
    arb_src_e         slots_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = slots_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        slots_d  = slots_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            slots_d[wr_ptr_q] = push_src;
            wr_ptr_d          = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        // Push and pop together leave the occupancy unchanged.
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= ARB_SRC_INST;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slots_q  <= slots_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data request
// ports: data-first priority, grants held until accepted, in-order response routing.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = ARB_OUTSTANDING_DEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    arb_src_e grant_src;
    logic     granted_req;
    logic     lock_q, lock_d;
    arb_src_e lock_src_q, lock_src_d;
    logic     fifo_full;
    logic     fifo_empty;
    arb_src_e fifo_head;
    logic     accept;

    // A stalled grant stays with its owner so a requester's fields never
    // switch underneath the downstream while it is deciding.
    always_comb begin
        grant_src = ARB_SRC_INST;
        if (lock_q) begin
            grant_src = lock_src_q;
        end else if (data_req) begin
            grant_src = ARB_SRC_DATA;
        end
    end

    always_comb begin
        granted_req = inst_req;
        mem_wr      = inst_wr;
        mem_size    = inst_size;
        mem_addr    = inst_addr;
        mem_wstrb   = inst_wstrb;
        mem_wdata   = inst_wdata;
        if (grant_src == ARB_SRC_DATA) begin
            granted_req = data_req;
            mem_wr      = data_wr;
            mem_size    = data_size;
            mem_addr    = data_addr;
            mem_wstrb   = data_wstrb;
            mem_wdata   = data_wdata;
        end
    end

    assign mem_req      = granted_req && !fifo_full && !reset;
    assign accept       = mem_req && mem_addr_ok;
    assign inst_addr_ok = accept && (grant_src == ARB_SRC_INST);
    assign data_addr_ok = accept && (grant_src == ARB_SRC_DATA);

    assign inst_data_ok = mem_data_ok && !fifo_empty && (fifo_head == ARB_SRC_INST) && !reset;
    assign data_data_ok = mem_data_ok && !fifo_empty && (fifo_head == ARB_SRC_DATA) && !reset;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        lock_d     = 1'b0;
        lock_src_d = lock_src_q;
        if (mem_req && !mem_addr_ok) begin
            lock_d     = 1'b1;
            lock_src_d = grant_src;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_src_q <= ARB_SRC_INST;
        end else begin
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

    arb_src_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_src_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_src (grant_src),
        .pop      (mem_data_ok),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed scoreboard bench for sram_req_arbiter: accepted requests queue
// their source, and each downstream response is checked against the queue head.
module tb_sram_req_arbiter;
    import sram_req_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int       checks = 0;
    int       errors = 0;
    arb_src_e exp_q[$];

    sram_req_arbiter #(.OUTSTANDING(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wstrb   (inst_wstrb),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge and are sampled 2ns later, well before the rising edge.
    task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                                 input logic d_req, input logic [31:0] d_addr,
                                 input logic m_aok, input logic m_dok, input logic [31:0] m_rdata);
        @(negedge clk);
        inst_req    = i_req;
        inst_addr   = i_addr;
        inst_wdata  = i_addr ^ 32'h5A5A_5A5A;
        data_req    = d_req;
        data_addr   = d_addr;
        data_wdata  = ~d_addr;
        mem_addr_ok = m_aok;
        mem_data_ok = m_dok;
        mem_rdata   = m_rdata;
        #2;
    endtask

    task automatic expect_accept(input string tag, input arb_src_e src, input logic [31:0] addr);
        logic is_data;
        is_data = (src == ARB_SRC_DATA);
        checkOutput({tag, "_mem_req"}, mem_req, 1'b1);
        checkOutput({tag, "_mem_addr"}, mem_addr, addr);
        checkOutput({tag, "_mem_wr"}, mem_wr, is_data);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, is_data ? ~addr : (addr ^ 32'h5A5A_5A5A));
        checkOutput({tag, "_mem_size"}, mem_size, is_data ? 2'd1 : 2'd2);
        checkOutput({tag, "_inst_addr_ok"}, inst_addr_ok, !is_data);
        checkOutput({tag, "_data_addr_ok"}, data_addr_ok, is_data);
        exp_q.push_back(src);
    endtask

    task automatic expect_stall(input string tag, input logic [31:0] addr);
        checkOutput({tag, "_mem_req"}, mem_req, 1'b1);
        checkOutput({tag, "_mem_addr"}, mem_addr, addr);
        checkOutput({tag, "_inst_addr_ok"}, inst_addr_ok, 1'b0);
        checkOutput({tag, "_data_addr_ok"}, data_addr_ok, 1'b0);
    endtask

    task automatic expect_blocked(input string tag);
        checkOutput({tag, "_mem_req"}, mem_req, 1'b0);
        checkOutput({tag, "_inst_addr_ok"}, inst_addr_ok, 1'b0);
        checkOutput({tag, "_data_addr_ok"}, data_addr_ok, 1'b0);
    endtask

    task automatic check_response(input string tag, input logic [31:0] rdata);
        arb_src_e src;
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_inst_data_ok"}, inst_data_ok, 1'b0);
            checkOutput({tag, "_data_data_ok"}, data_data_ok, 1'b0);
        end else begin
            src = exp_q.pop_front();
            checkOutput({tag, "_inst_data_ok"}, inst_data_ok, src == ARB_SRC_INST);
            checkOutput({tag, "_data_data_ok"}, data_data_ok, src == ARB_SRC_DATA);
            if (src == ARB_SRC_INST) checkOutput({tag, "_inst_rdata"}, inst_rdata, rdata);
            else                     checkOutput({tag, "_data_rdata"}, data_rdata, rdata);
        end
    endtask

    initial begin
        reset       = 1'b1;
        inst_req    = 1'b0;
        inst_wr     = 1'b0;
        inst_size   = 2'd2;
        inst_addr   = '0;
        inst_wstrb  = 4'h0;
        inst_wdata  = '0;
        data_req    = 1'b0;
        data_wr     = 1'b1;
        data_size   = 2'd1;
        data_addr   = '0;
        data_wstrb  = 4'hF;
        data_wdata  = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;

        // Outputs stay quiet under reset even with live requests and responses.
        applyStimulus(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1, 1'b1, 32'hFFFF_0000);
        expect_blocked("rst");
        checkOutput("rst_inst_data_ok", inst_data_ok, 1'b0);
        checkOutput("rst_data_data_ok", data_data_ok, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
        reset = 1'b0;

        // Data wins when both request; inst follows next cycle.
        applyStimulus(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1, 1'b0, 0);
        expect_accept("s1_data", ARB_SRC_DATA, 32'h2000);
        applyStimulus(1'b1, 32'h1000, 1'b0, 0, 1'b1, 1'b0, 0);
        expect_accept("s1_inst", ARB_SRC_INST, 32'h1000);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hAAAA_0001);
        check_response("s1_rsp0", 32'hAAAA_0001);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hAAAA_0002);
        check_response("s1_rsp1", 32'hAAAA_0002);

        // A stalled inst grant holds against a later data request.
        applyStimulus(1'b1, 32'hBFC0_0000, 1'b0, 0, 1'b0, 1'b0, 0);
        expect_stall("s2_c1", 32'hBFC0_0000);
        applyStimulus(1'b1, 32'hBFC0_0000, 1'b1, 32'h3000, 1'b0, 1'b0, 0);
        expect_stall("s2_c2", 32'hBFC0_0000);
        applyStimulus(1'b1, 32'hBFC0_0000, 1'b1, 32'h3000, 1'b0, 1'b0, 0);
        expect_stall("s2_c3", 32'hBFC0_0000);
        applyStimulus(1'b1, 32'hBFC0_0000, 1'b1, 32'h3000, 1'b1, 1'b0, 0);
        expect_accept("s2_c4", ARB_SRC_INST, 32'hBFC0_0000);
        applyStimulus(1'b0, 0, 1'b1, 32'h3000, 1'b1, 1'b0, 0);
        expect_accept("s2_c5", ARB_SRC_DATA, 32'h3000);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hBBBB_0001);
        check_response("s2_rsp0", 32'hBBBB_0001);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hBBBB_0002);
        check_response("s2_rsp1", 32'hBBBB_0002);

        // Full blocks acceptance, even in the cycle a response pops.
        applyStimulus(1'b1, 32'h4000, 1'b0, 0, 1'b1, 1'b0, 0);
        expect_accept("s3_a0", ARB_SRC_INST, 32'h4000);
        applyStimulus(1'b1, 32'h4000, 1'b0, 0, 1'b1, 1'b0, 0);
        expect_accept("s3_a1", ARB_SRC_INST, 32'h4000);
        applyStimulus(1'b1, 32'h4000, 1'b0, 0, 1'b1, 1'b0, 0);
        expect_blocked("s3_full");
        applyStimulus(1'b1, 32'h4000, 1'b0, 0, 1'b1, 1'b1, 32'h1234_5678);
        check_response("s3_rsp", 32'h1234_5678);
        expect_blocked("s3_nobypass");
        applyStimulus(1'b1, 32'h4000, 1'b0, 0, 1'b1, 1'b0, 0);
        expect_accept("s3_reaccept", ARB_SRC_INST, 32'h4000);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hCCCC_0001);
        check_response("s3_drain0", 32'hCCCC_0001);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hCCCC_0002);
        check_response("s3_drain1", 32'hCCCC_0002);

        // Push and pop in one cycle at count 1: exactly one more accept fits afterwards.
        applyStimulus(1'b0, 0, 1'b1, 32'h5000, 1'b1, 1'b0, 0);
        expect_accept("s4_a0", ARB_SRC_DATA, 32'h5000);
        applyStimulus(1'b1, 32'h6000, 1'b0, 0, 1'b1, 1'b1, 32'hBEEF_0001);
        check_response("s4_pop", 32'hBEEF_0001);
        expect_accept("s4_push", ARB_SRC_INST, 32'h6000);
        applyStimulus(1'b0, 0, 1'b1, 32'h7000, 1'b1, 1'b0, 0);
        expect_accept("s4_count1", ARB_SRC_DATA, 32'h7000);
        applyStimulus(1'b0, 0, 1'b1, 32'h7000, 1'b1, 1'b0, 0);
        expect_blocked("s4_full");
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hBEEF_0002);
        check_response("s4_drain0", 32'hBEEF_0002);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hBEEF_0003);
        check_response("s4_drain1", 32'hBEEF_0003);

        // Stray response on an empty FIFO is ignored and leaves the count at zero.
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hDEAD_0000);
        check_response("s5_empty", 32'hDEAD_0000);
        applyStimulus(1'b1, 32'h9000, 1'b0, 0, 1'b1, 1'b0, 0);
        expect_accept("s5_a0", ARB_SRC_INST, 32'h9000);
        applyStimulus(1'b1, 32'h9000, 1'b0, 0, 1'b1, 1'b0, 0);
        expect_accept("s5_a1", ARB_SRC_INST, 32'h9000);
        applyStimulus(1'b1, 32'h9000, 1'b0, 0, 1'b1, 1'b0, 0);
        expect_blocked("s5_full");

        // Asynchronous reset with two outstanding discards them immediately.
        @(posedge clk);
        #1;
        reset       = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hFACE_0000;
        #1;
        expect_blocked("s6_rst");
        checkOutput("s6_rst_inst_data_ok", inst_data_ok, 1'b0);
        checkOutput("s6_rst_data_data_ok", data_data_ok, 1'b0);
        exp_q.delete();
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hFACE_0001);
        check_response("s6_empty", 32'hFACE_0001);
        applyStimulus(1'b1, 32'h8000, 1'b0, 0, 1'b1, 1'b0, 0);
        expect_accept("s6_new", ARB_SRC_INST, 32'h8000);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 32'hFACE_0002);
        check_response("s6_rsp", 32'hFACE_0002);

        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
